// File: rtl/am_dds_modulator.sv
// am_dds_modulator: DDS phase accumulator -> sine ROM -> distance gain -> AM sample stream.
// Optional PWM DAC output enabled by defining PWM_OUT_EN.
`default_nettype none

module am_dds_modulator #(
  parameter int                DIST_W     = 13,
  parameter int                LOG2_MAX   = 11,
  parameter int                SINE_W     = 8,
  parameter int                PHASE_W    = 32,
  parameter int                LUT_ADDR_W = 8,
  parameter logic [PHASE_W-1:0] RESET_STEP = 32'h33333333
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic               freq_load,
  input  logic [PHASE_W-1:0] freq_step_in,
  input  logic [DIST_W-1:0]  distance,
  output logic [SINE_W-1:0]  sine_out,
  output logic [SINE_W-1:0]  am_out,
  output logic               out_valid,
  output logic               phase_wrap,
  output logic               pwm_out
);

  localparam int  c_LUT_N  = 1 << LUT_ADDR_W;
  localparam int  c_QUART  = c_LUT_N / 4;
  localparam int  c_PROD_W = SINE_W + LOG2_MAX + 1;
  localparam real c_PI     = 3.14159265358979323846;
  localparam logic [DIST_W-1:0] c_MAX_DIST = DIST_W'(1 << LOG2_MAX);

  // Taylor series; only ever called with 0 <= x <= pi/2 so it converges fast.
  function automatic real f_sin(input real x);
    real t;
    real s;
    t = x;
    s = x;
    for (int n = 1; n < 12; n++) begin
      t = -t * x * x / real'((2 * n) * (2 * n + 1));
      s = s + t;
    end
    return s;
  endfunction

  // Quadrant folding keeps the exact zero crossings and peaks free of rounding noise.
  function automatic logic [c_LUT_N*SINE_W-1:0] f_build_rom();
    logic [c_LUT_N*SINE_W-1:0] rom;
    real amp;
    real s;
    real v;
    int  q4;
    int  j;
    int  vi;
    amp = real'((1 << SINE_W) - 1) / 2.0;
    rom = '0;
    for (int k = 0; k < c_LUT_N; k++) begin
      q4 = k / c_QUART;
      j  = k % c_QUART;
      case (q4)
        0:       s =  f_sin(2.0 * c_PI * real'(j) / real'(c_LUT_N));
        1:       s =  f_sin(2.0 * c_PI * real'(c_QUART - j) / real'(c_LUT_N));
        2:       s = -f_sin(2.0 * c_PI * real'(j) / real'(c_LUT_N));
        default: s = -f_sin(2.0 * c_PI * real'(c_QUART - j) / real'(c_LUT_N));
      endcase
      v  = amp * (1.0 + s) + 0.5;
      vi = $rtoi(v);
      rom[k*SINE_W +: SINE_W] = vi[SINE_W-1:0];
    end
    return rom;
  endfunction

  localparam logic [c_LUT_N*SINE_W-1:0] c_ROM = f_build_rom();

  logic [SINE_W-1:0] w_rom [c_LUT_N];

  for (genvar gi = 0; gi < c_LUT_N; gi++) begin : g_rom
    assign w_rom[gi] = c_ROM[gi*SINE_W +: SINE_W];
  end

  logic                  w_advance;
  logic [PHASE_W:0]      w_sum;
  logic [LUT_ADDR_W-1:0] w_addr;
  logic [LOG2_MAX:0]     w_dist_sat;

  logic [PHASE_W-1:0]    r_phase;
  logic [PHASE_W-1:0]    r_step;
  logic                  r_wrap;
  logic [SINE_W-1:0]     r_sine1;
  logic [LOG2_MAX:0]     r_dist;
  logic [c_PROD_W-1:0]   r_prod;
  logic [SINE_W-1:0]     r_sine2;
  logic [SINE_W-1:0]     r_am;
  logic [SINE_W-1:0]     r_sine3;
  logic [2:0]            r_vld;

  assign w_sum      = {1'b0, r_phase} + {1'b0, r_step};
  assign w_addr     = r_phase[PHASE_W-1 -: LUT_ADDR_W];
  assign w_dist_sat = (distance >= c_MAX_DIST) ? {1'b1, {LOG2_MAX{1'b0}}}
                                               : distance[LOG2_MAX:0];

  // Step register follows freq_load even while the datapath is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step <= RESET_STEP;
    end else if (freq_load) begin
      r_step <= freq_step_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
      r_sine1 <= '0;
      r_dist  <= '0;
      r_prod  <= '0;
      r_sine2 <= '0;
      r_am    <= '0;
      r_sine3 <= '0;
      r_vld   <= '0;
    end else if (w_advance) begin
      r_phase <= phase_clr ? '0 : w_sum[PHASE_W-1:0];
      r_wrap  <= phase_clr ? 1'b0 : w_sum[PHASE_W];
      r_sine1 <= w_rom[w_addr];
      r_dist  <= w_dist_sat;
      r_prod  <= {{(LOG2_MAX+1){1'b0}}, r_sine1} * {{SINE_W{1'b0}}, r_dist};
      r_sine2 <= r_sine1;
      r_am    <= r_prod[SINE_W+LOG2_MAX-1 : LOG2_MAX];
      r_sine3 <= r_sine2;
      r_vld   <= {r_vld[1:0], 1'b1};
    end
  end

  // Gain never exceeds 1.0, so the product MSB and the fractional bits are discarded.
  logic w_unused_prod;
  assign w_unused_prod = ^{r_prod[c_PROD_W-1], r_prod[LOG2_MAX-1:0]};

  assign sine_out   = r_sine3;
  assign am_out     = r_am;
  assign out_valid  = r_vld[2];
  assign phase_wrap = r_wrap;

`ifdef PWM_OUT_EN
  localparam logic [SINE_W-1:0] c_CNT_MAX = SINE_W'((1 << SINE_W) - 2);

  logic              w_period_end;
  logic [SINE_W-1:0] r_cnt;
  logic [SINE_W-1:0] r_duty;
  logic              r_pwm;

  assign w_period_end = (r_cnt == c_CNT_MAX);
  assign w_advance    = enable & w_period_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else if (enable) begin
      r_cnt <= w_period_end ? '0 : r_cnt + 1'b1;
      if (w_period_end) begin
        r_duty <= r_am;
      end
      r_pwm <= (r_cnt < r_duty);
    end
  end

  assign pwm_out = r_pwm;
`else
  assign w_advance = enable;
  assign pwm_out   = 1'b0;
`endif

endmodule

`default_nettype wire
